// File: rtl/l2_bank_arbiter.sv
// Two-port TCDM arbiter in front of one single-port L2 SRAM bank, with a zero-fill sweep mode.
// Optional starvation guard for port 1: define L2_ARB_STARVE_GUARD_EN.

module l2_bank_arbiter_port #(
  parameter int          ADDR_WIDTH = 13,
  parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000
) (
  input  logic [31:0]           add_i,
  output logic [ADDR_WIDTH-1:0] waddr_o
);
  logic [31:0] w_off;
  logic        w_unused_off;

  // Out-of-bank upper bits are dropped silently; the bank aliases.
  assign w_off        = add_i - BASE_ADDR;
  assign waddr_o      = w_off[ADDR_WIDTH+1:2];
  assign w_unused_off = ^w_off;
endmodule

module l2_bank_arbiter #(
  parameter int          ADDR_WIDTH = 13,
  parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000,
  parameter int          MAX_WAIT   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  init_req_i,
  output logic                  init_done_o,

  input  logic                  p0_req_i,
  input  logic [31:0]           p0_add_i,
  input  logic                  p0_wen_i,
  input  logic [3:0]            p0_be_i,
  input  logic [31:0]           p0_wdata_i,
  output logic                  p0_gnt_o,
  output logic                  p0_r_valid_o,
  output logic [31:0]           p0_r_rdata_o,

  input  logic                  p1_req_i,
  input  logic [31:0]           p1_add_i,
  input  logic                  p1_wen_i,
  input  logic [3:0]            p1_be_i,
  input  logic [31:0]           p1_wdata_i,
  output logic                  p1_gnt_o,
  output logic                  p1_r_valid_o,
  output logic [31:0]           p1_r_rdata_o,

  output logic                  mem_csn_o,
  output logic                  mem_wen_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);
  localparam int                  NP   = 2;
  localparam logic [ADDR_WIDTH-1:0] LAST = {ADDR_WIDTH{1'b1}};

  typedef enum logic {SERVE = 1'b0, INIT = 1'b1} state_t;

  typedef struct packed {
    logic                  req;
    logic                  wen;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [ADDR_WIDTH-1:0] waddr;
  } preq_t;

  state_t                      r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]       r_cnt;
  logic [NP-1:0]               r_owner;
  logic [NP-1:0]               w_gnt;
  logic                        w_p1_first;
  logic                        w_last;

  logic [NP-1:0]               w_req, w_wen;
  logic [NP-1:0][3:0]          w_be;
  logic [NP-1:0][31:0]         w_add, w_wdata;
  logic [NP-1:0][ADDR_WIDTH-1:0] w_waddr;
  preq_t [NP-1:0]              w_preq;

  assign w_req   = {p1_req_i,   p0_req_i};
  assign w_wen   = {p1_wen_i,   p0_wen_i};
  assign w_be    = {p1_be_i,    p0_be_i};
  assign w_add   = {p1_add_i,   p0_add_i};
  assign w_wdata = {p1_wdata_i, p0_wdata_i};

  for (genvar g = 0; g < NP; g++) begin : g_port
    l2_bank_arbiter_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BASE_ADDR  (BASE_ADDR)
    ) u_port (
      .add_i   (w_add[g]),
      .waddr_o (w_waddr[g])
    );
    assign w_preq[g] = '{req: w_req[g], wen: w_wen[g], be: w_be[g],
                         wdata: w_wdata[g], waddr: w_waddr[g]};
  end

  // Port-1 starvation guard: after MAX_WAIT lost cycles p1 takes one win.
`ifdef L2_ARB_STARVE_GUARD_EN
  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  logic [WW-1:0] r_wait;

  assign w_p1_first = (r_wait == WW'(MAX_WAIT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wait <= '0;
    end else if (r_state == SERVE) begin
      if (!w_preq[1].req || w_gnt[1])  r_wait <= '0;
      else if (!w_p1_first)            r_wait <= r_wait + 1'b1;
    end
  end
`else
  localparam int unused_max_wait = MAX_WAIT;
  assign w_p1_first = 1'b0;
`endif

  always_comb begin
    w_gnt = '0;
    if (r_state == SERVE) begin
      if (w_p1_first && w_preq[1].req) w_gnt = 2'b10;
      else if (w_preq[0].req)          w_gnt = 2'b01;
      else if (w_preq[1].req)          w_gnt = 2'b10;
    end
  end

  assign w_last = (r_cnt == LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SERVE:   if (init_req_i) w_state_nxt = INIT;
      INIT:    if (w_last)     w_state_nxt = SERVE;
      default: w_state_nxt = SERVE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= SERVE;
      r_cnt   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_gnt;
      if (r_state == INIT && !w_last) r_cnt <= r_cnt + 1'b1;
      else                            r_cnt <= '0;
    end
  end

  always_comb begin
    mem_csn_o   = 1'b1;
    mem_wen_o   = 1'b1;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (r_state == INIT) begin
      mem_csn_o   = 1'b0;
      mem_wen_o   = 1'b0;
      mem_be_o    = 4'hF;
      mem_addr_o  = r_cnt;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (w_gnt[i]) begin
          mem_csn_o   = 1'b0;
          mem_wen_o   = w_preq[i].wen;
          mem_be_o    = w_preq[i].be;
          mem_addr_o  = w_preq[i].waddr;
          mem_wdata_o = w_preq[i].wdata;
        end
      end
    end
  end

  assign init_done_o  = (r_state == INIT) && w_last;
  assign p0_gnt_o     = w_gnt[0];
  assign p1_gnt_o     = w_gnt[1];
  assign p0_r_valid_o = r_owner[0];
  assign p1_r_valid_o = r_owner[1];
  assign p0_r_rdata_o = mem_rdata_i;
  assign p1_r_rdata_o = mem_rdata_i;
endmodule

// File: tb/tb_l2_bank_arbiter.sv
// Directed bench for l2_bank_arbiter (ADDR_WIDTH=4) with SRAM model and response scoreboard.

module tb_l2_bank_arbiter;
  localparam int          AW   = 4;
  localparam logic [31:0] BASE = 32'h1C00_0000;
`ifdef L2_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk, rst_n, init_req, init_done;
  logic          p0_req, p0_wen, p0_gnt, p0_rv;
  logic [31:0]   p0_add, p0_wdata, p0_rdata;
  logic [3:0]    p0_be;
  logic          p1_req, p1_wen, p1_gnt, p1_rv;
  logic [31:0]   p1_add, p1_wdata, p1_rdata;
  logic [3:0]    p1_be;
  logic          mem_csn, mem_wen;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  l2_bank_arbiter #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .MAX_WAIT(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .init_req_i(init_req), .init_done_o(init_done),
    .p0_req_i(p0_req), .p0_add_i(p0_add), .p0_wen_i(p0_wen), .p0_be_i(p0_be),
    .p0_wdata_i(p0_wdata), .p0_gnt_o(p0_gnt), .p0_r_valid_o(p0_rv), .p0_r_rdata_o(p0_rdata),
    .p1_req_i(p1_req), .p1_add_i(p1_add), .p1_wen_i(p1_wen), .p1_be_i(p1_be),
    .p1_wdata_i(p1_wdata), .p1_gnt_o(p1_gnt), .p1_r_valid_o(p1_rv), .p1_r_rdata_o(p1_rdata),
    .mem_csn_o(mem_csn), .mem_wen_o(mem_wen), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: byte-masked write, registered read.
  logic [31:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5_0000 | i;
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (!mem_csn) begin
      if (mem_wen) mem_rdata <= mem[mem_addr];
      else for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int n_done = 0;
  always @(negedge clk) if (init_done) n_done++;

  int n_tot = 0, n_pass = 0, n_fail = 0;

  typedef struct { logic [1:0] own; logic rd; logic [31:0] data; } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] own, input logic rd, input logic [31:0] data);
    exp_t e;
    e.own = own; e.rd = rd; e.data = data;
    sb.push_back(e);
  endtask

  // Advance one cycle and compare the response owed for the previous cycle.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      n_tot++; n_fail++;
      $error("FAIL sb_underflow: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      chk("p0_r_valid", 32'(p0_rv), 32'(e.own[0]));
      chk("p1_r_valid", 32'(p1_rv), 32'(e.own[1]));
      if (e.rd) chk("r_rdata", e.own[0] ? p0_rdata : p1_rdata, e.data);
    end
  endtask

  task automatic set_p0(input logic req, input logic wen, input logic [31:0] off,
                        input logic [3:0] be, input logic [31:0] wd);
    p0_req = req; p0_wen = wen; p0_add = BASE + off; p0_be = be; p0_wdata = wd;
  endtask

  task automatic set_p1(input logic req, input logic wen, input logic [31:0] off,
                        input logic [3:0] be, input logic [31:0] wd);
    p1_req = req; p1_wen = wen; p1_add = BASE + off; p1_be = be; p1_wdata = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_g1;
    rst_n = 1'b0; init_req = 1'b0;
    set_p0(0, 0, 0, 0, 0);
    set_p1(0, 0, 0, 0, 0);
    #1;
    chk("rst_p0_gnt", 32'(p0_gnt), 0);
    chk("rst_p1_gnt", 32'(p1_gnt), 0);
    chk("rst_rvalid", 32'({p1_rv, p0_rv}), 0);
    chk("rst_csn", 32'(mem_csn), 1);
    chk("rst_wen", 32'(mem_wen), 1);
    chk("rst_be", 32'(mem_be), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_done", 32'(init_done), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    push(0, 0, 0); tick();

    // p0 write then read back through the same word
    set_p0(1, 0, 32'h10, 4'hF, 32'hDEAD_BEEF); #1;
    chk("wr_gnt0", 32'(p0_gnt), 1);
    chk("wr_csn", 32'(mem_csn), 0);
    chk("wr_wen", 32'(mem_wen), 0);
    chk("wr_addr", 32'(mem_addr), 4);
    chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    push(2'b01, 0, 0); tick();
    set_p0(1, 1, 32'h10, 4'hF, 0); #1;
    chk("rd_gnt0", 32'(p0_gnt), 1);
    chk("rd_wen", 32'(mem_wen), 1);
    chk("rd_addr", 32'(mem_addr), 4);
    push(2'b01, 1, 32'hDEAD_BEEF); tick();

    // p1 partial write, both requesting (p0 wins), aliased upper bits
    set_p0(0, 0, 0, 0, 0);
    set_p1(1, 0, 32'h20, 4'b0011, 32'h1234_5678); #1;
    chk("p1wr_gnt1", 32'(p1_gnt), 1);
    chk("p1wr_be", 32'(mem_be), 32'h3);
    chk("p1wr_addr", 32'(mem_addr), 8);
    push(2'b10, 0, 0); tick();
    set_p0(1, 0, 32'h14, 4'hF, 32'h0BAD_F00D);
    set_p1(1, 1, 32'h20, 4'hF, 0); #1;
    chk("pri_gnt0", 32'(p0_gnt), 1);
    chk("pri_gnt1", 32'(p1_gnt), 0);
    chk("pri_addr", 32'(mem_addr), 5);
    chk("pri_wdata", mem_wdata, 32'h0BAD_F00D);
    push(2'b01, 0, 0); tick();
    set_p1(0, 0, 0, 0, 0);
    set_p1(1, 1, 32'h20, 4'hF, 0);
    set_p0(0, 0, 0, 0, 0); #1;
    chk("p1rd_gnt1", 32'(p1_gnt), 1);
    push(2'b10, 1, 32'hA5A5_5678); tick();
    set_p1(0, 0, 0, 0, 0);
    set_p0(1, 1, 32'h0010_0010, 4'hF, 0); #1;
    chk("alias_addr", 32'(mem_addr), 4);
    push(2'b01, 1, 32'hDEAD_BEEF); tick();
    set_p0(0, 0, 0, 0, 0);
    push(0, 0, 0); tick();

    // both requesting for 20 cycles
    set_p0(1, 1, 32'h10, 4'hF, 0);
    set_p1(1, 1, 32'h20, 4'hF, 0);
    for (int c = 1; c <= 20; c++) begin
      #1;
      exp_g1 = GUARD && (c == 9 || c == 18);
      chk($sformatf("starve_gnt1_c%0d", c), 32'(p1_gnt), 32'(exp_g1));
      chk($sformatf("starve_gnt0_c%0d", c), 32'(p0_gnt), 32'(!exp_g1));
      if (exp_g1) push(2'b10, 1, 32'hA5A5_5678);
      else        push(2'b01, 1, 32'hDEAD_BEEF);
      tick();
    end
    set_p0(0, 0, 0, 0, 0);
    set_p1(0, 0, 0, 0, 0);
    push(0, 0, 0); tick();

    // p1 grant in the init_req cycle, then full sweep with p0 held off
    set_p1(1, 1, 32'h20, 4'hF, 0);
    init_req = 1'b1; #1;
    chk("initreq_gnt1", 32'(p1_gnt), 1);
    push(2'b10, 1, 32'hA5A5_5678); tick();
    init_req = 1'b0;
    set_p1(0, 0, 0, 0, 0);
    set_p0(1, 1, 32'h10, 4'hF, 0);
    for (int i = 0; i < 16; i++) begin
      init_req = (i == 3);
      #1;
      chk($sformatf("init_gnt0_%0d", i), 32'(p0_gnt), 0);
      chk($sformatf("init_addr_%0d", i), 32'(mem_addr), i);
      chk($sformatf("init_wr_%0d", i), {mem_csn, mem_wen, mem_be}, 32'h0F);
      chk($sformatf("init_wdata_%0d", i), mem_wdata, 0);
      chk($sformatf("init_done_%0d", i), 32'(init_done), 32'(i == 15));
      push(0, 0, 0); tick();
    end
    init_req = 1'b0; #1;
    chk("post_init_gnt0", 32'(p0_gnt), 1);
    push(2'b01, 1, 32'h0); tick();
    set_p0(1, 1, 32'h20, 4'hF, 0);
    push(2'b01, 1, 32'h0); tick();
    set_p0(0, 0, 0, 0, 0);
    push(0, 0, 0); tick();

    // reset in the middle of a sweep
    init_req = 1'b1;
    push(0, 0, 0); tick();
    init_req = 1'b0;
    for (int i = 0; i < 7; i++) begin push(0, 0, 0); tick(); end
    #1;
    chk("mid_addr7", 32'(mem_addr), 7);
    rst_n = 1'b0; #1;
    chk("mid_rst_csn", 32'(mem_csn), 1);
    chk("mid_rst_wen", 32'(mem_wen), 1);
    chk("mid_rst_addr", 32'(mem_addr), 0);
    chk("mid_rst_done", 32'(init_done), 0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    set_p0(1, 0, 32'h3C, 4'hF, 32'hCAFE_0001); #1;
    chk("rel_gnt0", 32'(p0_gnt), 1);
    chk("rel_addr", 32'(mem_addr), 15);
    push(2'b01, 0, 0); tick();
    set_p0(1, 1, 32'h3C, 4'hF, 0); #1;
    push(2'b01, 1, 32'hCAFE_0001); tick();
    set_p0(0, 0, 0, 0, 0);
    push(0, 0, 0); tick();
    chk("done_pulses", 32'(n_done), 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
